// File: rtl/count_readout.sv
// count_readout: histogram bin store with a sequential drain port.
//
// Counts occurrences of each NUM_W-bit sample value in IDLE. On i_start it scans
// every bin in ascending order and streams (value, count) beats over a
// valid/ready interface, clearing each bin as its beat is accepted.
//
// Ports:
//   clk, rstn         clock, synchronous active-low reset
//   i_valid, i_num    sample strobe and value (counted only in IDLE)
//   i_start           drain request, honoured only in IDLE
//   o_busy            high while draining; samples arriving then are dropped
//   o_valid, i_ready  output beat handshake
//   o_num, o_cnt      bin index and count of the current beat
//   o_done            one-cycle pulse at the end of a drain
//   o_drop            registered pulse when a sample arrived while busy
module count_readout #(
  parameter int unsigned NUM_W     = 8,
  parameter int unsigned CNT_W     = 8,
  parameter bit          SKIP_ZERO = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_valid,
  input  logic [NUM_W-1:0] i_num,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [NUM_W-1:0] o_num,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_done,
  output logic             o_drop
);

  localparam int unsigned      NumBins = 2 ** NUM_W;
  localparam logic [NUM_W-1:0] LastIdx = NUM_W'(NumBins - 1);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  typedef enum logic [1:0] {StIdle, StScan, StOut, StDone} state_e;

  state_e           state_q, state_d;
  logic [NUM_W-1:0] idx_q, idx_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             drop_q, drop_d;
  logic [CNT_W-1:0] bins_q [NumBins];
  logic [CNT_W-1:0] bins_d [NumBins];

  // State register (bins, scan index and beat registers included).
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
      idx_q   <= '0;
      num_q   <= '0;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
      bins_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      bins_q  <= bins_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    num_d   = num_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d = StScan;
          idx_d   = '0;
        end
      end
      StScan: begin
        if ((bins_q[idx_q] != '0) || !SKIP_ZERO) begin
          // Beat registers are loaded here so they stay stable through OUT.
          num_d   = idx_q;
          cnt_d   = bins_q[idx_q];
          state_d = StOut;
        end else if (idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StOut: begin
        if (i_ready) begin
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StScan;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
    endcase
  end

  // Bin updates: saturating increment while idle, clear on an accepted beat.
  // The two never coincide since they are qualified by different states.
  always_comb begin
    bins_d = bins_q;
    if ((state_q == StIdle) && i_valid && (bins_q[i_num] != CntMax)) begin
      bins_d[i_num] = bins_q[i_num] + 1'b1;
    end
    if ((state_q == StOut) && i_ready) begin
      bins_d[idx_q] = '0;
    end
  end

  assign drop_d = i_valid && (state_q != StIdle);

  // Outputs are pure state decodes / registers; nothing depends on i_ready.
  always_comb begin
    o_busy  = (state_q != StIdle);
    o_valid = (state_q == StOut);
    o_done  = (state_q == StDone);
    o_num   = num_q;
    o_cnt   = cnt_q;
    o_drop  = drop_q;
  end

endmodule

// File: tb/tb_count_readout.sv
module tb_count_readout;

  logic       clk = 1'b0;
  logic       rstn;
  logic       i_valid;
  logic [7:0] i_num;
  logic       i_start;
  logic       i_ready;

  logic       a_busy, a_valid, a_done, a_drop;
  logic [7:0] a_num, a_cnt;
  logic       b_busy, b_valid, b_done, b_drop;
  logic [7:0] b_num, b_cnt;

  // Selects which instance the drain task observes (0: SKIP_ZERO=1, 1: SKIP_ZERO=0).
  logic       sel;
  logic       s_busy, s_valid, s_done, s_drop;
  logic [7:0] s_num, s_cnt;

  assign s_busy  = sel ? b_busy  : a_busy;
  assign s_valid = sel ? b_valid : a_valid;
  assign s_done  = sel ? b_done  : a_done;
  assign s_drop  = sel ? b_drop  : a_drop;
  assign s_num   = sel ? b_num   : a_num;
  assign s_cnt   = sel ? b_cnt   : a_cnt;

  always #5 clk = ~clk;

  count_readout #(.NUM_W(8), .CNT_W(8), .SKIP_ZERO(1'b1)) u_dut_skip (
    .clk     (clk),
    .rstn    (rstn),
    .i_valid (i_valid),
    .i_num   (i_num),
    .i_start (i_start),
    .o_busy  (a_busy),
    .o_valid (a_valid),
    .i_ready (i_ready),
    .o_num   (a_num),
    .o_cnt   (a_cnt),
    .o_done  (a_done),
    .o_drop  (a_drop)
  );

  count_readout #(.NUM_W(8), .CNT_W(8), .SKIP_ZERO(1'b0)) u_dut_all (
    .clk     (clk),
    .rstn    (rstn),
    .i_valid (i_valid),
    .i_num   (i_num),
    .i_start (i_start),
    .o_busy  (b_busy),
    .o_valid (b_valid),
    .i_ready (i_ready),
    .o_num   (b_num),
    .o_cnt   (b_cnt),
    .o_done  (b_done),
    .o_drop  (b_drop)
  );

  int checks   = 0;
  int failures = 0;

  int q_num[$];
  int q_cnt[$];
  int first_valid_n;
  int done_n;
  int busy_n;
  int drop_n;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int num);
    i_valid = 1'b1;
    i_num   = 8'(num);
    tick();
    i_valid = 1'b0;
  endtask

  task automatic do_reset;
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  // Pulse i_start and run until o_done (bounded). Cycle n=1 is the cycle right
  // after the edge that samples i_start. stall = cycles of i_ready low per beat;
  // inj_n = cycle in which a value-9 sample is injected (-1 for none).
  task automatic drain(input int stall, input int inj_n, input int budget);
    int         n;
    int         wait_c;
    bit         done;
    logic [7:0] hn, hc;
    q_num.delete();
    q_cnt.delete();
    first_valid_n = -1;
    done_n        = -1;
    busy_n        = 0;
    drop_n        = 0;
    hn            = '0;
    hc            = '0;
    i_ready       = (stall == 0);
    i_start       = 1'b1;
    tick();
    i_start = 1'b0;
    i_valid = 1'b0;
    n       = 1;
    wait_c  = 0;
    done    = 1'b0;
    while (!done && n <= budget) begin
      if (s_busy) busy_n++;
      if (s_drop) drop_n++;
      if (s_done) begin
        done_n = n;
        done   = 1'b1;
      end
      i_valid = (n == inj_n);
      i_num   = 8'd9;
      if (s_valid) begin
        if (first_valid_n < 0) first_valid_n = n;
        if (wait_c == 0) begin
          hn = s_num;
          hc = s_cnt;
        end else begin
          check("stall_num", 32'(s_num), 32'(hn));
          check("stall_cnt", 32'(s_cnt), 32'(hc));
        end
        if (wait_c < stall) begin
          i_ready = 1'b0;
          wait_c++;
        end else begin
          i_ready = 1'b1;
          q_num.push_back(int'(s_num));
          q_cnt.push_back(int'(s_cnt));
          wait_c = 0;
        end
      end else begin
        i_ready = (stall == 0);
      end
      tick();
      n++;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    if (!done) check("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic expect_beat(input string tag, input int idx, input int num, input int cnt);
    if (idx < q_num.size()) begin
      check({tag, "_num"}, 32'(q_num[idx]), 32'(num));
      check({tag, "_cnt"}, 32'(q_cnt[idx]), 32'(cnt));
    end else begin
      check({tag, "_missing"}, 32'(q_num.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    int bad;
    int w;
    sel     = 1'b0;
    rstn    = 1'b0;
    i_valid = 1'b0;
    i_num   = '0;
    i_start = 1'b0;
    i_ready = 1'b1;
    tick();
    tick();
    rstn = 1'b1;

    // Reset state.
    check("rst_valid", 32'(a_valid), 32'd0);
    check("rst_busy",  32'(a_busy),  32'd0);
    check("rst_done",  32'(a_done),  32'd0);
    check("rst_drop",  32'(a_drop),  32'd0);
    check("rst_num",   32'(a_num),   32'd0);
    check("rst_cnt",   32'(a_cnt),   32'd0);

    // Empty histogram: no beats, done 257 cycles after the start edge.
    drain(0, -1, 600);
    check("empty_beats", 32'(q_num.size()), 32'd0);
    check("empty_done_n", 32'(done_n), 32'd257);
    check("empty_busy_n", 32'(busy_n), 32'd257);
    check("empty_idle", 32'(a_busy), 32'd0);

    // Basic drain in ascending order, bin 0 beat two cycles after start edge.
    feed(5); feed(5); feed(5); feed(200); feed(0);
    drain(0, -1, 600);
    check("basic_beats", 32'(q_num.size()), 32'd3);
    expect_beat("basic_b0", 0, 0, 1);
    expect_beat("basic_b1", 1, 5, 3);
    expect_beat("basic_b2", 2, 200, 1);
    check("basic_first_valid_n", 32'(first_valid_n), 32'd2);
    check("basic_drop_n", 32'(drop_n), 32'd0);
    drain(0, -1, 600);
    check("basic_redrain_beats", 32'(q_num.size()), 32'd0);

    // Saturation at 255.
    for (int k = 0; k < 300; k++) feed(7);
    drain(0, -1, 600);
    check("sat_beats", 32'(q_num.size()), 32'd1);
    expect_beat("sat_b0", 0, 7, 255);

    // Backpressure: 10 stalled cycles per beat, outputs held stable.
    feed(3); feed(4);
    drain(10, -1, 800);
    check("stall_beats", 32'(q_num.size()), 32'd2);
    expect_beat("stall_b0", 0, 3, 1);
    expect_beat("stall_b1", 1, 4, 1);
    drain(0, -1, 600);
    check("stall_redrain_beats", 32'(q_num.size()), 32'd0);

    // Sample with start is counted; sample during drain is dropped.
    i_valid = 1'b1;
    i_num   = 8'd9;
    drain(0, 3, 600);
    check("drop_beats", 32'(q_num.size()), 32'd1);
    expect_beat("drop_b0", 0, 9, 1);
    check("drop_n", 32'(drop_n), 32'd1);
    drain(0, -1, 600);
    check("drop_redrain_beats", 32'(q_num.size()), 32'd0);

    // Reset while a beat is stalled aborts the drain and clears the bins.
    feed(1); feed(2); feed(2);
    i_ready = 1'b0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    w = 0;
    while (!a_valid && w < 20) begin
      tick();
      w++;
    end
    check("abort_valid_seen", 32'(a_valid), 32'd1);
    check("abort_num", 32'(a_num), 32'd1);
    check("abort_cnt", 32'(a_cnt), 32'd1);
    do_reset();
    i_ready = 1'b1;
    check("abort_rst_valid", 32'(a_valid), 32'd0);
    check("abort_rst_busy", 32'(a_busy), 32'd0);
    check("abort_rst_num", 32'(a_num), 32'd0);
    drain(0, -1, 600);
    check("abort_redrain_beats", 32'(q_num.size()), 32'd0);

    // SKIP_ZERO=0 instance: an empty drain emits every bin with count 0.
    do_reset();
    sel = 1'b1;
    drain(0, -1, 1200);
    check("all_beats", 32'(q_num.size()), 32'd256);
    bad = 0;
    for (int k = 0; k < q_num.size(); k++) begin
      if (q_num[k] != k || q_cnt[k] != 0) bad++;
    end
    check("all_beat_values_bad", 32'(bad), 32'd0);
    check("all_done_n", 32'(done_n), 32'd513);
    sel = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
